// File: rtl/rr_ps_pkg.sv
// Shared defaults for the rotating-priority selectors: grant counts per use site
// and the single-step modulo helper used when rotating request/grant vectors.
package rr_ps_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int ISSUE_NUM_GNTS = 3;
  localparam int CDB_NUM_GNTS   = 2;

  // Inputs never exceed 2*modulus-1, so one conditional subtract is an exact mod.
  function automatic int wrap_idx(input int idx, input int modulus);
    return (idx >= modulus) ? idx - modulus : idx;
  endfunction

endpackage

// File: rtl/rr_ps_fixed_multi.sv
// Fixed-priority (high index first) multi-grant core: NUM_GNTS cascaded single
// selectors, each seeing only the requests left over by the stages before it.
module ps_fixed_multi
  import rr_ps_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_GNTS = ISSUE_NUM_GNTS
) (
  input  logic [WIDTH-1:0]          req,
  output logic [NUM_GNTS*WIDTH-1:0] gnt_bus
);

  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] stage_gnt;
  logic             found;

  always_comb begin
    remaining = req;
    stage_gnt = '0;
    found     = 1'b0;
    gnt_bus   = '0;
    for (int k = 0; k < NUM_GNTS; k++) begin
      stage_gnt = '0;
      found     = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!found && remaining[i]) begin
          stage_gnt[i] = 1'b1;
          found        = 1'b1;
        end
      end
      gnt_bus[k*WIDTH +: WIDTH] = stage_gnt;
      remaining                 = remaining & ~stage_gnt;
    end
  end

endmodule

// File: rtl/rr_ps.sv
// Rotating-priority multi-grant selector: rotates requests so ptr is the top slot,
// runs the fixed-priority core, un-rotates, and moves ptr just past the last grant.
module rr_ps
  import rr_ps_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_GNTS = ISSUE_NUM_GNTS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              req,
  input  logic                          en,
  input  logic                          stall,
  output logic [WIDTH-1:0]              gnt,
  output logic [NUM_GNTS*WIDTH-1:0]     gnt_bus,
  output logic [$clog2(NUM_GNTS+1)-1:0] num_gnt,
  output logic [$clog2(WIDTH)-1:0]      ptr
);

  localparam int PW  = $clog2(WIDTH);
  localparam int NGW = $clog2(NUM_GNTS + 1);

  logic [WIDTH-1:0]          req_eff;
  logic [WIDTH-1:0]          req_rot;
  logic [NUM_GNTS*WIDTH-1:0] rot_bus;
  logic [WIDTH-1:0]          slice_rot;
  logic [WIDTH-1:0]          slice_orig;
  logic [PW-1:0]             last_idx;

  // Rotated bit j holds original index (ptr+1+j) mod WIDTH, so bit WIDTH-1 is ptr itself.
  always_comb begin
    req_eff = (en && !reset) ? req : '0;
    req_rot = '0;
    for (int j = 0; j < WIDTH; j++) begin
      req_rot[j] = req_eff[PW'(wrap_idx(int'(ptr) + 1 + j, WIDTH))];
    end
  end

  ps_fixed_multi #(
    .WIDTH    (WIDTH),
    .NUM_GNTS (NUM_GNTS)
  ) u_core (
    .req     (req_rot),
    .gnt_bus (rot_bus)
  );

  always_comb begin
    gnt        = '0;
    gnt_bus    = '0;
    num_gnt    = '0;
    last_idx   = '0;
    slice_rot  = '0;
    slice_orig = '0;
    for (int k = 0; k < NUM_GNTS; k++) begin
      slice_rot = rot_bus[k*WIDTH +: WIDTH];
      for (int i = 0; i < WIDTH; i++) begin
        slice_orig[i] = slice_rot[PW'(wrap_idx(i + WIDTH - 1 - int'(ptr), WIDTH))];
      end
      gnt_bus[k*WIDTH +: WIDTH] = slice_orig;
      gnt                       = gnt | slice_orig;
      // Slices fill from k=0 upward, so the last non-empty one holds the lowest-priority grant.
      if (|slice_orig) begin
        num_gnt = NGW'(k + 1);
        for (int i = 0; i < WIDTH; i++) begin
          if (slice_orig[i]) last_idx = PW'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= PW'(WIDTH - 1);
    end else if (en && !stall && (num_gnt != '0)) begin
      ptr <= (last_idx == '0) ? PW'(WIDTH - 1) : last_idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_ps.sv
// Directed bench for rr_ps at WIDTH=8, NUM_GNTS=2 with hand-computed grants and pointer moves.
module tb_rr_ps;

  localparam int WIDTH    = 8;
  localparam int NUM_GNTS = 2;

  logic                          clock;
  logic                          reset;
  logic [WIDTH-1:0]              req;
  logic                          en;
  logic                          stall;
  logic [WIDTH-1:0]              gnt;
  logic [NUM_GNTS*WIDTH-1:0]     gnt_bus;
  logic [$clog2(NUM_GNTS+1)-1:0] num_gnt;
  logic [$clog2(WIDTH)-1:0]      ptr;

  int checkCount = 0;
  int errorCount = 0;

  rr_ps #(
    .WIDTH    (WIDTH),
    .NUM_GNTS (NUM_GNTS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .en      (en),
    .stall   (stall),
    .gnt     (gnt),
    .gnt_bus (gnt_bus),
    .num_gnt (num_gnt),
    .ptr     (ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic [WIDTH-1:0] r, input logic e,
                               input logic s, input logic rst);
    @(negedge clock);
    req   = r;
    en    = e;
    stall = s;
    reset = rst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] expPtr,
                          input logic [31:0] expGnt, input logic [31:0] expBus,
                          input logic [31:0] expNum);
    checkOutput({tag, ".ptr"},     32'(ptr),     expPtr);
    checkOutput({tag, ".gnt"},     32'(gnt),     expGnt);
    checkOutput({tag, ".gnt_bus"}, 32'(gnt_bus), expBus);
    checkOutput({tag, ".num_gnt"}, 32'(num_gnt), expNum);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    en    = 1'b1;
    stall = 1'b0;

    // Reset held with active requests: outputs forced to zero, ptr at WIDTH-1.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
    checkAll("reset_hold", 32'd7, 32'h00, 32'h0000, 32'd0);

    // Full request stream walks the pointer 7->5->3->1 and wraps to 7.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("full_p7", 32'd7, 32'hC0, 32'h4080, 32'd2);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("full_p5", 32'd5, 32'h30, 32'h1020, 32'd2);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("full_p3", 32'd3, 32'h0C, 32'h0408, 32'd2);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("full_p1", 32'd1, 32'h03, 32'h0102, 32'd2);

    // Last grant at index 0 wraps ptr to 7; req=0 then holds it.
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkAll("wrap_idle", 32'd7, 32'h00, 32'h0000, 32'd0);

    // Single request far from ptr: one grant, second slice empty.
    applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    checkAll("single_p7", 32'd7, 32'h04, 32'h0004, 32'd1);

    // Steer ptr to 0 by granting index 1 from ptr=1.
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
    checkAll("steer_p1", 32'd1, 32'h02, 32'h0002, 32'd1);

    // Wrap inside one cycle: ptr=0 grants 0 first, then 7.
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
    checkAll("wrap_p0", 32'd0, 32'h81, 32'h8001, 32'd2);

    // Next ptr is 6; grant index 6 to move ptr to 5.
    applyStimulus(8'h40, 1'b1, 1'b0, 1'b0);
    checkAll("steer_p6", 32'd6, 32'h40, 32'h0040, 32'd1);

    // Stall: grants still driven, pointer frozen at 5.
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    checkAll("stall_a", 32'd5, 32'h30, 32'h1020, 32'd2);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    checkAll("stall_b", 32'd5, 32'h30, 32'h1020, 32'd2);

    // Disabled: no grants, ptr holds.
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    checkAll("en_low", 32'd5, 32'h00, 32'h0000, 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkAll("req_zero_a", 32'd5, 32'h00, 32'h0000, 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkAll("req_zero_b", 32'd5, 32'h00, 32'h0000, 32'd0);

    // Grant 5,4 so ptr lands on 3, then reset mid-stream.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("pre_reset", 32'd5, 32'h30, 32'h1020, 32'd2);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
    checkAll("mid_reset", 32'd3, 32'h00, 32'h0000, 32'd0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    checkAll("post_reset", 32'd7, 32'hC0, 32'h4080, 32'd2);

    // Sparse wrap from ptr=5: grants 5 then 0, last grant 0 sends ptr to 7.
    applyStimulus(8'h21, 1'b1, 1'b0, 1'b0);
    checkAll("sparse_p5", 32'd5, 32'h21, 32'h0120, 32'd2);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkAll("sparse_after", 32'd7, 32'h00, 32'h0000, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
